// File: rtl/multdiv_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
// The pipeline is the master; the multdiv unit responds.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_RDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_RDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_RDY
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (shift-add) / divider (restoring), one bit per cycle.
// Every operation takes exactly ITER cycles from start to the single-cycle RDY pulse.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic     clock,
    input  logic     resetn,
    multdiv_if.slave bus
);
    localparam int CW = 6;

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 sign_q;
    logic                 divz_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH:0]       dvsr_q;
    logic [WIDTH-1:0]     result_q;
    logic                 exc_q;
    logic                 rdy_q;

    // Magnitudes as unsigned: the most negative value maps onto itself, which is correct unsigned.
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    logic [2*WIDTH-1:0] acc_d, prod;
    logic               mul_exc;
    assign acc_d   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign prod    = sign_q ? -acc_d : acc_d;
    assign mul_exc = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

    logic [WIDTH:0]   shifted, rem_d;
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic [WIDTH-1:0] quo_d, quo_signed;
    logic             div_ovf;
    assign shifted    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial      = {1'b0, shifted} - {1'b0, dvsr_q};
    assign fits       = !trial[WIDTH+1];
    assign rem_d      = fits ? trial[WIDTH:0] : shifted;
    assign quo_d      = {quo_q[WIDTH-2:0], fits};
    assign quo_signed = sign_q ? -quo_d : quo_d;
    // Only MIN / -1 yields a positive quotient with the top bit set.
    assign div_ovf    = !sign_q && quo_d[WIDTH-1];

    logic last;
    assign last = (cnt_q == CW'(ITER - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            divz_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ctrl_MULT || bus.ctrl_DIV) begin
                        cnt_q  <= '0;
                        sign_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                        divz_q <= (bus.data_operandB == '0);
                        if (bus.ctrl_MULT) begin
                            state_q  <= MULT;
                            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                            mplier_q <= b_mag;
                            acc_q    <= '0;
                        end else begin
                            state_q <= DIV;
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dvsr_q  <= {1'b0, b_mag};
                        end
                    end
                end
                MULT: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) begin
                        result_q <= prod[WIDTH-1:0];
                        exc_q    <= mul_exc;
                        rdy_q    <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        result_q <= divz_q ? '0 : quo_signed;
                        exc_q    <= divz_q || div_ovf;
                        rdy_q    <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    rdy_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_RDY       = rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed table, busy/back-to-back/reset sequences, then random ops
// compared against a plain-arithmetic signed model.
module tb_multdiv_unit;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32), .ITER(32)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int sa, sb, q;
        logic [31:0] lo;
        if (is_mul) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            lo = p[31:0];
            return {(p != longint'($signed(lo))), lo};
        end
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) return {1'b1, 32'h0};
        if (sa == 32'sh8000_0000 && sb == -1) return {1'b1, 32'h8000_0000};
        q = sa / sb;
        return {1'b0, 32'(q)};
    endfunction

    // Start at edge 0, watch edges 1..33; optionally pulse a second start at edge 'disturb'.
    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit exp_exc, input int disturb,
                          input string name);
        int rdy_cnt = 0;
        int rdy_edge = -1;
        logic [31:0] r = 'x;
        logic e = 1'bx;
        @(negedge clock);
        bus.ctrl_MULT = m;
        bus.ctrl_DIV = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        for (int i = 1; i <= 33; i++) begin
            if (i == disturb) begin
                bus.ctrl_DIV = 1'b1;
                bus.ctrl_MULT = 1'b1;
            end
            @(posedge clock);
            #1;
            bus.ctrl_DIV = 1'b0;
            bus.ctrl_MULT = 1'b0;
            if (bus.data_RDY === 1'b1) begin
                rdy_cnt++;
                rdy_edge = i;
                r = bus.data_result;
                e = bus.data_exception;
            end
        end
        check({name, " rdy_count"}, rdy_cnt, 1);
        check({name, " rdy_edge"}, rdy_edge, 32);
        check({name, " result"}, r, exp_res);
        check({name, " exception"}, {31'b0, e}, {31'b0, exp_exc});
    endtask

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
        string       name;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int seen;
        logic [32:0] exp;
        logic [31:0] ra, rb;
        bit rm;

        tbl[0] = '{0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7x-3"};
        tbl[1] = '{0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1, "mul_ovf"};
        tbl[2] = '{0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, "mul_min_x1"};
        tbl[3] = '{1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, "div_-7/2"};
        tbl[4] = '{1, 32'd100,        32'd7,         32'd14,        0, "div_100/7"};
        tbl[5] = '{1, 32'd5,          32'd0,         32'd0,         1, "div_by0"};
        tbl[6] = '{1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, "div_min/-1"};

        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset result", bus.data_result, 32'h0);
        check("reset exception", {31'b0, bus.data_exception}, 32'h0);
        check("reset rdy", {31'b0, bus.data_RDY}, 32'h0);
        resetn = 1'b1;

        foreach (tbl[i])
            run_op(!tbl[i].is_div, tbl[i].is_div, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc, 0, tbl[i].name);

        run_op(1, 0, 32'd3, 32'd4, 32'd12, 0, 10, "busy_ignore");
        run_op(0, 1, 32'hFFFF_FF9C, 32'd10, 32'hFFFF_FFF6, 0, 0, "back_to_back");
        run_op(1, 1, 32'd5, 32'd6, 32'd30, 0, 0, "both_ctrls");

        // Asynchronous reset in the middle of a multiply.
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'd11;
        bus.data_operandB = 32'd13;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("midreset result", bus.data_result, 32'h0);
        check("midreset exception", {31'b0, bus.data_exception}, 32'h0);
        check("midreset rdy", {31'b0, bus.data_RDY}, 32'h0);
        @(posedge clock);
        #3;
        resetn = 1'b1;
        seen = 0;
        for (int i = 12; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.data_RDY === 1'b1) seen++;
        end
        check("midreset no_rdy", seen, 0);
        run_op(0, 1, 32'd9, 32'd3, 32'd3, 0, 0, "after_reset_div");

        for (int n = 0; n < 24; n++) begin
            rm = $urandom_range(0, 1);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3: rb = $urandom_range(1, 1000);
                4: begin ra = $urandom_range(0, 65535); rb = 32'(-$urandom_range(1, 65535)); end
                default: rb = $urandom;
            endcase
            exp = model(rm, ra, rb);
            run_op(rm, !rm, ra, rb, exp[31:0], exp[32], 0, rm ? "rand_mul" : "rand_div");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
